// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit memory that services MR reads and MW writes one at a time with fixed latency.
// Build option MEM_WRFWD_EN: a same-word read+write pair retires together, with the write data forwarded to d_out.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 3
) (
    input  logic        clk,
    input  logic        r,
    input  logic        re,
    input  logic [31:0] r_addr,
    input  logic        we,
    input  logic [31:0] w_addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        r_finished,
    output logic        w_finished
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBUSY = 2'd1,
        RBUSY = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           data_q;
    logic                  fwd_q;

    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  fwd_take;

    logic                  commit_w;
    logic                  commit_r;
    logic                  fwd_now;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic [31:0]           op_data;

    logic [31:0] mem [DEPTH];

    assign r_idx = r_addr[DEPTH_LOG2+1:2];
    assign w_idx = w_addr[DEPTH_LOG2+1:2];

    // Byte-lane bits and address bits above the array are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{r_addr[31:DEPTH_LOG2+2], r_addr[1:0],
                                w_addr[31:DEPTH_LOG2+2], w_addr[1:0]};

`ifdef MEM_WRFWD_EN
    assign fwd_take = we && re && (r_idx == w_idx);
`else
    assign fwd_take = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (we) begin
                    state_next = (WR_LAT == 1) ? RESP : WBUSY;
                end else if (re) begin
                    state_next = (RD_LAT == 1) ? RESP : RBUSY;
                end
            end
            WBUSY: begin
                if (cnt == CNT_ONE) begin
                    state_next = RESP;
                end
            end
            RBUSY: begin
                if (cnt == CNT_ONE) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A single-cycle latency commits straight out of IDLE, using the live request inputs.
    always_comb begin
        commit_w = 1'b0;
        commit_r = 1'b0;
        fwd_now  = fwd_q;
        op_idx   = idx_q;
        op_data  = data_q;
        unique case (state)
            IDLE: begin
                op_idx   = we ? w_idx : r_idx;
                op_data  = d_in;
                fwd_now  = fwd_take;
                commit_w = we && (WR_LAT == 1);
                commit_r = !we && re && (RD_LAT == 1);
            end
            WBUSY: begin
                commit_w = (cnt == CNT_ONE);
            end
            RBUSY: begin
                commit_r = (cnt == CNT_ONE);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            cnt    <= '0;
            idx_q  <= '0;
            data_q <= '0;
            fwd_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (we) begin
                        cnt    <= WR_LOAD;
                        idx_q  <= w_idx;
                        data_q <= d_in;
                        fwd_q  <= fwd_take;
                    end else if (re) begin
                        cnt    <= RD_LOAD;
                        idx_q  <= r_idx;
                        fwd_q  <= 1'b0;
                    end
                end
                WBUSY, RBUSY: begin
                    cnt <= cnt - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // The array is never cleared; a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (commit_w && !r) begin
            mem[op_idx] <= op_data;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            d_out      <= '0;
            r_finished <= 1'b0;
            w_finished <= 1'b0;
        end else begin
            w_finished <= commit_w;
            r_finished <= commit_r || (commit_w && fwd_now);
            if (commit_r) begin
                d_out <= mem[op_idx];
            end else if (commit_w && fwd_now) begin
                d_out <= op_data;
            end
        end
    end

`ifndef MEM_WRFWD_EN
    always_ff @(posedge clk) begin
        if (!r) begin
            assert (!(r_finished && w_finished));
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic checked against an array model.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int RD_LAT     = 3;
    localparam int WR_LAT     = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int LIMIT      = 40;

    logic        clk = 1'b0;
    logic        r;
    logic        re;
    logic        we;
    logic [31:0] r_addr;
    logic [31:0] w_addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        r_finished;
    logic        w_finished;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];
    logic [31:0] last_dout;
    int          written_idx [$];

    mem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk       (clk),
        .r         (r),
        .re        (re),
        .r_addr    (r_addr),
        .we        (we),
        .w_addr    (w_addr),
        .d_in      (d_in),
        .d_out     (d_out),
        .r_finished(r_finished),
        .w_finished(w_finished)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Builds a byte address for a word with random byte-lane and out-of-range high bits.
    function automatic logic [31:0] alias_addr(input int idx);
        return 32'(idx) * 4 + 32'($urandom_range(0, 3)) + 32'($urandom_range(0, 255)) * 32'(4 * DEPTH);
    endfunction

    task automatic apply_stimulus(input logic rst_v, input logic re_v, input logic we_v,
                                  input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] data);
        r      = rst_v;
        re     = re_v;
        we     = we_v;
        r_addr = ra;
        w_addr = wa;
        d_in   = data;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        model_mem[word_of(addr)]   = data;
        model_known[word_of(addr)] = 1'b1;
        written_idx.push_back(word_of(addr));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int lat;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0, addr, data);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_output({tag, " no read pulse"}, {31'b0, r_finished}, 32'h0);
        end while (!w_finished && lat < LIMIT);
        check_output({tag, " write latency"}, 32'(lat), 32'(WR_LAT));
        we = 1'b0;
        model_write(addr, data);
        @(negedge clk);
        check_output({tag, " write pulse width"}, {31'b0, w_finished}, 32'h0);
        check_output({tag, " d_out held"}, d_out, last_dout);
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag);
        int          lat;
        logic [31:0] expected;
        expected = model_mem[word_of(addr)];
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, addr, 32'h0, 32'h0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_output({tag, " no write pulse"}, {31'b0, w_finished}, 32'h0);
        end while (!r_finished && lat < LIMIT);
        check_output({tag, " read latency"}, 32'(lat), 32'(RD_LAT));
        check_output({tag, " read data"}, d_out, expected);
        re        = 1'b0;
        last_dout = expected;
        @(negedge clk);
        check_output({tag, " read pulse width"}, {31'b0, r_finished}, 32'h0);
        check_output({tag, " read data held"}, d_out, expected);
    endtask

    task automatic do_both(input logic [31:0] raddr, input logic [31:0] waddr,
                           input logic [31:0] data, input string tag);
        int          cyc;
        int          wl;
        int          rl;
        bit          same;
        int          exp_wl;
        int          exp_rl;
        logic [31:0] expected;
        expected = (word_of(raddr) == word_of(waddr)) ? data : model_mem[word_of(raddr)];
`ifdef MEM_WRFWD_EN
        same = (word_of(raddr) == word_of(waddr));
`else
        same = 1'b0;
`endif
        exp_wl = WR_LAT;
        exp_rl = same ? WR_LAT : WR_LAT + 1 + RD_LAT;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b1, raddr, waddr, data);
        cyc = 0;
        wl  = -1;
        rl  = -1;
        while ((wl < 0 || rl < 0) && cyc < 2 * LIMIT) begin
            @(negedge clk);
            cyc++;
            if (w_finished && wl < 0) begin
                wl = cyc;
                we = 1'b0;
            end
            if (r_finished && rl < 0) begin
                rl = cyc;
                re = 1'b0;
                check_output({tag, " read data"}, d_out, expected);
            end
        end
        re = 1'b0;
        we = 1'b0;
        check_output({tag, " write latency"}, 32'(wl), 32'(exp_wl));
        check_output({tag, " read latency"}, 32'(rl), 32'(exp_rl));
        model_write(waddr, data);
        last_dout = expected;
        @(negedge clk);
        check_output({tag, " pulses cleared"}, {30'b0, r_finished, w_finished}, 32'h0);
    endtask

    initial begin
        logic [31:0] hold_addrs [4];
        int          cyc;
        int          prev;
        int          pulses;
        int          op;
        int          idx;
        logic [31:0] wa;
        logic [31:0] ra;

        last_dout = 32'h0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        check_output("reset d_out", d_out, 32'h0);
        check_output("reset r_finished", {31'b0, r_finished}, 32'h0);
        check_output("reset w_finished", {31'b0, w_finished}, 32'h0);

        // Array contents survive a reset
        do_write(32'h14, 32'h1234, "preload");
        do_read(32'h14, "preload rd");
        @(negedge clk);
        r = 1'b1;
        repeat (2) @(negedge clk);
        r = 1'b0;
        last_dout = 32'h0;
        check_output("rereset d_out", d_out, 32'h0);
        check_output("rereset pulses", {30'b0, r_finished, w_finished}, 32'h0);
        do_read(32'h14, "after reset rd");

        // Write then read back
        do_write(32'h14, 32'hABCD, "wr abcd");
        do_read(32'h14, "rd abcd");

        // Simultaneous request to the same word
        do_both(32'h8, 32'h8, 32'h55, "both same");

        // Index wrap and byte-lane bits ignored
        do_write(32'h1003, 32'hCAFE_0001, "wr wrap");
        do_read(32'h0, "rd wrap");

        // Reset on the commit edge of a pending write
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h14, 32'hDEAD_BEEF);
        repeat (WR_LAT - 1) @(negedge clk);
        check_output("abort before commit", {31'b0, w_finished}, 32'h0);
        r = 1'b1;
        @(negedge clk);
        check_output("abort no pulse", {30'b0, r_finished, w_finished}, 32'h0);
        @(negedge clk);
        check_output("abort still quiet", {30'b0, r_finished, w_finished}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        last_dout = 32'h0;
        check_output("abort d_out", d_out, 32'h0);
        do_read(32'h14, "rd after abort");

        // Held read request, four back-to-back transactions
        do_write(32'h40, 32'h4444, "wr 40");
        hold_addrs[0] = 32'h14;
        hold_addrs[1] = 32'h8000_0008;
        hold_addrs[2] = 32'h3;
        hold_addrs[3] = 32'h40;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, hold_addrs[0], 32'h0, 32'h0);
        cyc    = 0;
        prev   = 0;
        pulses = 0;
        while (pulses < 4 && cyc < 4 * LIMIT) begin
            @(negedge clk);
            cyc++;
            check_output("held no write pulse", {31'b0, w_finished}, 32'h0);
            if (r_finished) begin
                check_output("held spacing", 32'(cyc),
                             32'((pulses == 0) ? RD_LAT : prev + RD_LAT + 1));
                check_output("held data", d_out, model_mem[word_of(hold_addrs[pulses])]);
                last_dout = model_mem[word_of(hold_addrs[pulses])];
                prev = cyc;
                pulses++;
                if (pulses < 4) begin
                    r_addr = hold_addrs[pulses];
                end
            end
        end
        re = 1'b0;
        check_output("held pulse count", 32'(pulses), 32'd4);
        @(negedge clk);
        check_output("held pulse cleared", {31'b0, r_finished}, 32'h0);

        // Randomized traffic against the array model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write($urandom, $urandom, "rand wr");
            end else if (op == 1) begin
                idx = written_idx[$urandom_range(0, written_idx.size() - 1)];
                do_read(alias_addr(idx), "rand rd");
            end else begin
                wa = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    ra = alias_addr(word_of(wa));
                end else begin
                    ra = alias_addr(written_idx[$urandom_range(0, written_idx.size() - 1)]);
                end
                do_both(ra, wa, $urandom, "rand both");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
